// File: rtl/mvm_ctrl_part1.sv
// Control FSM for the 3x3 matrix-vector datapath: loads W then x, sequences ROWS dot products.
// Optional build macro MVM_REUSE_W_EN adds reuse_w to skip the W load and reuse memory contents.
module mvm_ctrl_part1 #(
  parameter int unsigned ROWS = 3,
  parameter int unsigned COLS = 3,
  parameter int unsigned AW_X = 2,
  parameter int unsigned AW_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
`ifdef MVM_REUSE_W_EN
  input  logic            reuse_w,
`endif
  input  logic            s_valid,
  output logic            s_ready,
  output logic [AW_X-1:0] addr_x,
  output logic            wr_en_x,
  output logic [AW_W-1:0] addr_w,
  output logic            wr_en_w,
  output logic            clear_acc,
  output logic            en_acc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW_W-1:0] row_idx,
  output logic            busy,
  output logic            done
);

  localparam int unsigned N_W = ROWS * COLS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_X,
    S_CLEAR,
    S_MAC,
    S_OUT
  } state_t;

  state_t          state_q, state_d;
  logic [AW_W-1:0] cnt_q, cnt_d;
  logic [AW_W-1:0] row_q, row_d;
  logic [AW_X-1:0] col_q, col_d;

  logic            s_ready_d, clear_acc_d, en_acc_d, out_valid_d, busy_d;
  logic [AW_X-1:0] addr_x_d;
  logic [AW_W-1:0] addr_w_d;
  logic            beat;
  logic            reuse_sel;

`ifdef MVM_REUSE_W_EN
  assign reuse_sel = reuse_w;
`else
  assign reuse_sel = 1'b0;
`endif

  assign beat = s_valid & s_ready;

  // Next state, counters, and the registered-output values derived from the next state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    col_d       = col_q;
    s_ready_d   = 1'b0;
    clear_acc_d = 1'b0;
    en_acc_d    = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b1;
    addr_x_d    = '0;
    addr_w_d    = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = reuse_sel ? S_LOAD_X : S_LOAD_W;
          cnt_d   = '0;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_LOAD_W: begin
        if (beat) begin
          if (cnt_q == AW_W'(N_W - 1)) begin
            state_d = S_LOAD_X;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + AW_W'(1);
          end
        end
      end
      S_LOAD_X: begin
        if (beat) begin
          if (cnt_q == AW_W'(COLS - 1)) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + AW_W'(1);
          end
        end
      end
      S_CLEAR: begin
        col_d   = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        if (col_q == AW_X'(COLS - 1)) begin
          state_d = S_OUT;
          col_d   = '0;
        end else begin
          col_d = col_q + AW_X'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (row_q == AW_W'(ROWS - 1)) begin
            state_d = S_IDLE;
            row_d   = '0;
          end else begin
            state_d = S_CLEAR;
            row_d   = row_q + AW_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so decode them from where the FSM is heading
    case (state_d)
      S_IDLE: begin
        clear_acc_d = 1'b1;
        busy_d      = 1'b0;
      end
      S_LOAD_W: begin
        s_ready_d = 1'b1;
        addr_w_d  = cnt_d;
      end
      S_LOAD_X: begin
        s_ready_d = 1'b1;
        addr_x_d  = AW_X'(cnt_d);
      end
      S_CLEAR: clear_acc_d = 1'b1;
      S_MAC: begin
        en_acc_d = 1'b1;
        addr_x_d = col_d;
        addr_w_d = AW_W'(32'(row_d) * COLS + 32'(col_d));
      end
      S_OUT:   out_valid_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  // State, counters and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      s_ready   <= 1'b0;
      clear_acc <= 1'b1;
      en_acc    <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      addr_x    <= '0;
      addr_w    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      s_ready   <= s_ready_d;
      clear_acc <= clear_acc_d;
      en_acc    <= en_acc_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      addr_x    <= addr_x_d;
      addr_w    <= addr_w_d;
    end
  end

  // Write strobes follow the handshake in the same cycle
  assign wr_en_w = beat & (state_q == S_LOAD_W);
  assign wr_en_x = beat & (state_q == S_LOAD_X);
  assign row_idx = row_q;
  assign done    = out_valid & out_ready & (row_q == AW_W'(ROWS - 1));

endmodule
